// File: rtl/bsg_dfi_fifo_bridge_pkg.sv
// Shared types and constants for the DFI-to-FIFO bridge.
package bsg_dfi_fifo_bridge_pkg;

  localparam int unsigned cmd_width_lp = 26;

  // Bit positions inside fifo_error_o
  localparam int unsigned err_wr_lp  = 0;
  localparam int unsigned err_cmd_lp = 1;
  localparam int unsigned err_rd_lp  = 2;
  localparam int unsigned err_w_lp   = 3;

  typedef struct packed {
    logic [2:0]  bank;
    logic [15:0] address;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic        reset_n;
    logic        odt;
  } dfi_cmd_s;

endpackage

// File: rtl/bsg_dfi_fifo_bridge_buf.sv
// Single-clock 1r1w buffer with valid/ready output; enqueue into a full buffer is dropped.
module bsg_dfi_fifo_bridge_buf #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic                v_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign full_o = (cnt_r == cnt_w_lp'(els_p));
  assign enq    = v_i & ~full_o;
  assign deq    = v_r & ready_i;
  assign v_o    = v_r;
  assign data_o = mem_r[rd_ptr_r];

  always_comb begin
    cnt_n = cnt_r;
    case ({enq, deq})
      2'b10:   cnt_n = cnt_r + cnt_w_lp'(1);
      2'b01:   cnt_n = cnt_r - cnt_w_lp'(1);
      default: cnt_n = cnt_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      v_r      <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      cnt_r <= cnt_n;
      v_r   <= (cnt_n != '0);
    end
  end

  // Storage needs no reset; validity is tracked by cnt_r.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_dfi_fifo_bridge.sv
// Single-clock DFI <-> FIFO bridge: write-beat packing, command queueing, read unpacking.
// Optional BSG_DFI_FIFO_BRIDGE_STATS_EN adds 32-bit traffic counters.
module bsg_dfi_fifo_bridge
  import bsg_dfi_fifo_bridge_pkg::*;
#(
  parameter int unsigned dq_data_width_p  = 32,
  parameter int unsigned beats_per_word_p = 2,
  parameter int unsigned wr_els_p         = 8,
  parameter int unsigned cmd_els_p        = 4,
  parameter int unsigned rd_latency_p     = 2,
  localparam int unsigned dq_group_lp     = dq_data_width_p / 8,
  localparam int unsigned beat_w_lp       = 2 * dq_data_width_p + 2 * dq_group_lp,
  localparam int unsigned rd_beat_w_lp    = 2 * dq_data_width_p
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [2:0]                               dfi_bank_i,
  input  logic [15:0]                              dfi_address_i,
  input  logic                                     dfi_cke_i,
  input  logic                                     dfi_cs_n_i,
  input  logic                                     dfi_ras_n_i,
  input  logic                                     dfi_cas_n_i,
  input  logic                                     dfi_we_n_i,
  input  logic                                     dfi_reset_n_i,
  input  logic                                     dfi_odt_i,
  input  logic                                     dfi_wrdata_en_i,
  input  logic [2*dq_data_width_p-1:0]             dfi_wrdata_i,
  input  logic [2*dq_group_lp-1:0]                 dfi_wrdata_mask_i,
  input  logic                                     dfi_rddata_en_i,
  output logic [rd_beat_w_lp-1:0]                  dfi_rddata_o,
  output logic                                     dfi_rddata_valid_o,
  output logic                                     fifo_wr_v_o,
  input  logic                                     fifo_wr_ready_i,
  output logic [beats_per_word_p*beat_w_lp-1:0]    fifo_wr_data_o,
  output logic                                     fifo_cmd_v_o,
  input  logic                                     fifo_cmd_ready_i,
  output logic [cmd_width_lp-1:0]                  fifo_cmd_data_o,
  input  logic                                     fifo_rd_v_i,
  input  logic [beats_per_word_p*rd_beat_w_lp-1:0] fifo_rd_data_i,
  output logic                                     fifo_rd_yumi_o,
  input  logic                                     error_clear_i,
`ifdef BSG_DFI_FIFO_BRIDGE_STATS_EN
  output logic [31:0]                              stat_wr_words_o,
  output logic [31:0]                              stat_cmds_o,
  output logic [31:0]                              stat_rd_words_o,
`endif
  output logic [err_w_lp-1:0]                      fifo_error_o
);

  localparam int unsigned bcnt_w_lp = (beats_per_word_p > 1) ? $clog2(beats_per_word_p) : 1;
  localparam logic [bcnt_w_lp-1:0] last_beat_lp = bcnt_w_lp'(beats_per_word_p - 1);

  // ---------------- write path ----------------
  logic [beats_per_word_p-1:0][beat_w_lp-1:0] wr_slots_r, wr_word;
  logic [bcnt_w_lp-1:0] wr_beat_cnt_r;
  logic [beat_w_lp-1:0] wr_beat;
  logic                 wr_last, wr_enq, wr_full, wr_ovf;

  assign wr_beat = {dfi_wrdata_i, dfi_wrdata_mask_i};
  assign wr_last = (wr_beat_cnt_r == last_beat_lp);
  assign wr_enq  = dfi_wrdata_en_i & wr_last;
  assign wr_ovf  = wr_enq & wr_full;

  // Final beat bypasses its slot so the word enqueues on the same edge.
  always_comb begin
    wr_word = wr_slots_r;
    wr_word[beats_per_word_p-1] = wr_beat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_beat_cnt_r <= '0;
      wr_slots_r    <= '0;
    end else if (dfi_wrdata_en_i) begin
      wr_slots_r[wr_beat_cnt_r] <= wr_beat;
      wr_beat_cnt_r <= wr_last ? '0 : wr_beat_cnt_r + bcnt_w_lp'(1);
    end
  end

  bsg_dfi_fifo_bridge_buf #(
    .width_p(beats_per_word_p * beat_w_lp),
    .els_p  (wr_els_p)
  ) wr_buf (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (wr_enq),
    .data_i (wr_word),
    .full_o (wr_full),
    .v_o    (fifo_wr_v_o),
    .data_o (fifo_wr_data_o),
    .ready_i(fifo_wr_ready_i)
  );

  // ---------------- command path ----------------
  dfi_cmd_s cmd;
  logic     cmd_enq, cmd_full, cmd_ovf;

  always_comb begin
    cmd.bank    = dfi_bank_i;
    cmd.address = dfi_address_i;
    cmd.cke     = dfi_cke_i;
    cmd.cs_n    = dfi_cs_n_i;
    cmd.ras_n   = dfi_ras_n_i;
    cmd.cas_n   = dfi_cas_n_i;
    cmd.we_n    = dfi_we_n_i;
    cmd.reset_n = dfi_reset_n_i;
    cmd.odt     = dfi_odt_i;
  end

  assign cmd_enq = ~dfi_cs_n_i;
  assign cmd_ovf = cmd_enq & cmd_full;

  bsg_dfi_fifo_bridge_buf #(
    .width_p(cmd_width_lp),
    .els_p  (cmd_els_p)
  ) cmd_buf (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (cmd_enq),
    .data_i (cmd),
    .full_o (cmd_full),
    .v_o    (fifo_cmd_v_o),
    .data_o (fifo_cmd_data_o),
    .ready_i(fifo_cmd_ready_i)
  );

  // ---------------- read path ----------------
  logic [rd_latency_p-1:0] rd_pipe_r;
  logic [beats_per_word_p-1:0][rd_beat_w_lp-1:0] rd_word;
  logic [bcnt_w_lp-1:0] rd_beat_cnt_r;
  logic                 rd_fire, rd_last, rd_unf;

  assign rd_word            = fifo_rd_data_i;
  assign dfi_rddata_valid_o = rd_pipe_r[rd_latency_p-1];
  assign rd_fire            = dfi_rddata_valid_o & fifo_rd_v_i;
  assign rd_last            = (rd_beat_cnt_r == last_beat_lp);
  assign rd_unf             = dfi_rddata_valid_o & ~fifo_rd_v_i;
  assign fifo_rd_yumi_o     = rd_fire & rd_last;
  assign dfi_rddata_o       = rd_fire ? rd_word[rd_beat_cnt_r] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pipe_r     <= '0;
      rd_beat_cnt_r <= '0;
    end else begin
      rd_pipe_r[0] <= dfi_rddata_en_i;
      for (int i = 1; i < int'(rd_latency_p); i++) rd_pipe_r[i] <= rd_pipe_r[i-1];
      if (rd_fire) rd_beat_cnt_r <= rd_last ? '0 : rd_beat_cnt_r + bcnt_w_lp'(1);
    end
  end

  // ---------------- sticky errors (set beats clear) ----------------
  logic [err_w_lp-1:0] err_r, err_set;

  always_comb begin
    err_set = '0;
    err_set[err_wr_lp]  = wr_ovf;
    err_set[err_cmd_lp] = cmd_ovf;
    err_set[err_rd_lp]  = rd_unf;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_r <= '0;
    else         err_r <= (error_clear_i ? '0 : err_r) | err_set;
  end

  assign fifo_error_o = err_r;

`ifdef BSG_DFI_FIFO_BRIDGE_STATS_EN
  logic [31:0] stat_wr_r, stat_cmd_r, stat_rd_r;

  always_ff @(posedge clk_i) begin
    if (reset_i | error_clear_i) begin
      stat_wr_r  <= '0;
      stat_cmd_r <= '0;
      stat_rd_r  <= '0;
    end else begin
      if (wr_enq & ~wr_full)   stat_wr_r  <= stat_wr_r + 32'(1);
      if (cmd_enq & ~cmd_full) stat_cmd_r <= stat_cmd_r + 32'(1);
      if (fifo_rd_yumi_o)      stat_rd_r  <= stat_rd_r + 32'(1);
    end
  end

  assign stat_wr_words_o = stat_wr_r;
  assign stat_cmds_o     = stat_cmd_r;
  assign stat_rd_words_o = stat_rd_r;
`endif

endmodule

// File: tb/tb_bsg_dfi_fifo_bridge.sv
// Directed self-checking bench for bsg_dfi_fifo_bridge at default parameters.
module tb_bsg_dfi_fifo_bridge;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [2:0]   dfi_bank_i;
  logic [15:0]  dfi_address_i;
  logic         dfi_cke_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i, dfi_reset_n_i, dfi_odt_i;
  logic         dfi_wrdata_en_i;
  logic [63:0]  dfi_wrdata_i;
  logic [7:0]   dfi_wrdata_mask_i;
  logic         dfi_rddata_en_i;
  logic [63:0]  dfi_rddata_o;
  logic         dfi_rddata_valid_o;
  logic         fifo_wr_v_o, fifo_wr_ready_i;
  logic [143:0] fifo_wr_data_o;
  logic         fifo_cmd_v_o, fifo_cmd_ready_i;
  logic [25:0]  fifo_cmd_data_o;
  logic         fifo_rd_v_i;
  logic [127:0] fifo_rd_data_i;
  logic         fifo_rd_yumi_o;
  logic         error_clear_i;
  logic [2:0]   fifo_error_o;
`ifdef BSG_DFI_FIFO_BRIDGE_STATS_EN
  logic [31:0]  stat_wr_words_o, stat_cmds_o, stat_rd_words_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_dfi_fifo_bridge dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .dfi_bank_i        (dfi_bank_i),
    .dfi_address_i     (dfi_address_i),
    .dfi_cke_i         (dfi_cke_i),
    .dfi_cs_n_i        (dfi_cs_n_i),
    .dfi_ras_n_i       (dfi_ras_n_i),
    .dfi_cas_n_i       (dfi_cas_n_i),
    .dfi_we_n_i        (dfi_we_n_i),
    .dfi_reset_n_i     (dfi_reset_n_i),
    .dfi_odt_i         (dfi_odt_i),
    .dfi_wrdata_en_i   (dfi_wrdata_en_i),
    .dfi_wrdata_i      (dfi_wrdata_i),
    .dfi_wrdata_mask_i (dfi_wrdata_mask_i),
    .dfi_rddata_en_i   (dfi_rddata_en_i),
    .dfi_rddata_o      (dfi_rddata_o),
    .dfi_rddata_valid_o(dfi_rddata_valid_o),
    .fifo_wr_v_o       (fifo_wr_v_o),
    .fifo_wr_ready_i   (fifo_wr_ready_i),
    .fifo_wr_data_o    (fifo_wr_data_o),
    .fifo_cmd_v_o      (fifo_cmd_v_o),
    .fifo_cmd_ready_i  (fifo_cmd_ready_i),
    .fifo_cmd_data_o   (fifo_cmd_data_o),
    .fifo_rd_v_i       (fifo_rd_v_i),
    .fifo_rd_data_i    (fifo_rd_data_i),
    .fifo_rd_yumi_o    (fifo_rd_yumi_o),
    .error_clear_i     (error_clear_i),
`ifdef BSG_DFI_FIFO_BRIDGE_STATS_EN
    .stat_wr_words_o   (stat_wr_words_o),
    .stat_cmds_o       (stat_cmds_o),
    .stat_rd_words_o   (stat_rd_words_o),
`endif
    .fifo_error_o      (fifo_error_o)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bdata(input int w, input int b);
    return {32'(w), 32'hA000_0000 | 32'(b)};
  endfunction

  function automatic logic [7:0] bmask(input int w, input int b);
    return 8'(w * 2 + b);
  endfunction

  function automatic logic [25:0] cmd_of(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v[2:0], 16'h0100 + v[15:0], 1'b1, 1'b0, v[0], v[1], 1'b1, 1'b1, v[0]};
  endfunction

  task automatic set_cmd(input int i);
    logic [31:0] v;
    v = 32'(i);
    dfi_cs_n_i    = 1'b0;
    dfi_bank_i    = v[2:0];
    dfi_address_i = 16'h0100 + v[15:0];
    dfi_cke_i     = 1'b1;
    dfi_ras_n_i   = v[0];
    dfi_cas_n_i   = v[1];
    dfi_we_n_i    = 1'b1;
    dfi_reset_n_i = 1'b1;
    dfi_odt_i     = v[0];
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] m);
    dfi_wrdata_en_i   = 1'b1;
    dfi_wrdata_i      = d;
    dfi_wrdata_mask_i = m;
    cyc();
    dfi_wrdata_en_i   = 1'b0;
  endtask

  initial begin
    logic [63:0] da, db, dc, dd, d0, d1, d2, d3;
    reset_i = 1'b1;
    {dfi_bank_i, dfi_address_i, dfi_cke_i, dfi_ras_n_i, dfi_cas_n_i} = '0;
    {dfi_we_n_i, dfi_reset_n_i, dfi_odt_i} = '0;
    dfi_cs_n_i = 1'b1;
    dfi_wrdata_en_i = 1'b0; dfi_wrdata_i = '0; dfi_wrdata_mask_i = '0;
    dfi_rddata_en_i = 1'b0;
    fifo_wr_ready_i = 1'b0; fifo_cmd_ready_i = 1'b0;
    fifo_rd_v_i = 1'b0; fifo_rd_data_i = '0;
    error_clear_i = 1'b0;
    cyc(); cyc();
    reset_i = 1'b0;
    #1;
    chk("rst_wr_v", 256'(fifo_wr_v_o), 256'(0));
    chk("rst_cmd_v", 256'(fifo_cmd_v_o), 256'(0));
    chk("rst_err", 256'(fifo_error_o), 256'(0));
    chk("rst_rd_valid", 256'(dfi_rddata_valid_o), 256'(0));
    chk("rst_yumi", 256'(fifo_rd_yumi_o), 256'(0));
    chk("rst_rddata", 256'(dfi_rddata_o), 256'(0));

    // Write packing with a gap between beats
    da = 64'h1111_2222_3333_4444; db = 64'h5555_6666_7777_8888;
    push_beat(da, 8'h0F);
    cyc();
    chk("pack_v_mid", 256'(fifo_wr_v_o), 256'(0));
    push_beat(db, 8'hF0);
    chk("pack_v", 256'(fifo_wr_v_o), 256'(1));
    chk("pack_word", 256'(fifo_wr_data_o), 256'({db, 8'hF0, da, 8'h0F}));
    chk("pack_err", 256'(fifo_error_o), 256'(0));
    fifo_wr_ready_i = 1'b1;
    cyc();
    fifo_wr_ready_i = 1'b0;
    chk("pack_drained", 256'(fifo_wr_v_o), 256'(0));

    // Write overflow: 9 words into an 8-deep buffer
    for (int w = 0; w < 9; w++)
      for (int b = 0; b < 2; b++) push_beat(bdata(w, b), bmask(w, b));
    chk("wovf_err", 256'(fifo_error_o), 256'(3'b001));
    fifo_wr_ready_i = 1'b1;
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("wovf_v%0d", w), 256'(fifo_wr_v_o), 256'(1));
      chk($sformatf("wovf_d%0d", w), 256'(fifo_wr_data_o),
          256'({bdata(w, 1), bmask(w, 1), bdata(w, 0), bmask(w, 0)}));
      cyc();
    end
    fifo_wr_ready_i = 1'b0;
    chk("wovf_empty", 256'(fifo_wr_v_o), 256'(0));
    error_clear_i = 1'b1;
    cyc();
    error_clear_i = 1'b0;
    chk("wovf_clr", 256'(fifo_error_o), 256'(0));

    // Command overflow, then clear colliding with a new overflow
    for (int i = 0; i < 5; i++) begin
      set_cmd(i);
      cyc();
    end
    dfi_cs_n_i = 1'b1;
    chk("covf_err", 256'(fifo_error_o), 256'(3'b010));
    chk("covf_v", 256'(fifo_cmd_v_o), 256'(1));
    set_cmd(9);
    error_clear_i = 1'b1;
    cyc();
    dfi_cs_n_i = 1'b1;
    error_clear_i = 1'b0;
    chk("covf_set_wins", 256'(fifo_error_o), 256'(3'b010));
    error_clear_i = 1'b1;
    cyc();
    error_clear_i = 1'b0;
    chk("covf_clr", 256'(fifo_error_o), 256'(0));
    fifo_cmd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cmd_d%0d", i), 256'(fifo_cmd_data_o), 256'(cmd_of(i)));
      cyc();
    end
    fifo_cmd_ready_i = 1'b0;
    chk("cmd_empty", 256'(fifo_cmd_v_o), 256'(0));

    // Read unpack: two beats of one word, yumi on the second
    d0 = 64'hDEAD_0000_0000_0D00; d1 = 64'hBEEF_0000_0000_0D01;
    fifo_rd_v_i = 1'b1; fifo_rd_data_i = {d1, d0};
    dfi_rddata_en_i = 1'b1;
    cyc();
    chk("rd_valid_early", 256'(dfi_rddata_valid_o), 256'(0));
    cyc();
    dfi_rddata_en_i = 1'b0;
    chk("rd_valid0", 256'(dfi_rddata_valid_o), 256'(1));
    chk("rd_beat0", 256'(dfi_rddata_o), 256'(d0));
    chk("rd_yumi0", 256'(fifo_rd_yumi_o), 256'(0));
    cyc();
    chk("rd_valid1", 256'(dfi_rddata_valid_o), 256'(1));
    chk("rd_beat1", 256'(dfi_rddata_o), 256'(d1));
    chk("rd_yumi1", 256'(fifo_rd_yumi_o), 256'(1));
    cyc();
    chk("rd_valid_end", 256'(dfi_rddata_valid_o), 256'(0));
    chk("rd_err", 256'(fifo_error_o), 256'(0));

    // Read underflow, then the late word supplies beat 0
    fifo_rd_v_i = 1'b0;
    dfi_rddata_en_i = 1'b1;
    cyc();
    dfi_rddata_en_i = 1'b0;
    cyc();
    chk("unf_valid", 256'(dfi_rddata_valid_o), 256'(1));
    chk("unf_data", 256'(dfi_rddata_o), 256'(0));
    chk("unf_yumi", 256'(fifo_rd_yumi_o), 256'(0));
    cyc();
    chk("unf_err", 256'(fifo_error_o), 256'(3'b100));
    d2 = 64'h0123_4567_89AB_CDEF; d3 = 64'hFEDC_BA98_7654_3210;
    fifo_rd_v_i = 1'b1; fifo_rd_data_i = {d3, d2};
    dfi_rddata_en_i = 1'b1;
    cyc();
    dfi_rddata_en_i = 1'b0;
    cyc();
    chk("late_valid", 256'(dfi_rddata_valid_o), 256'(1));
    chk("late_beat0", 256'(dfi_rddata_o), 256'(d2));
    chk("late_yumi", 256'(fifo_rd_yumi_o), 256'(0));
    cyc();
    fifo_rd_v_i = 1'b0;

    // Reset mid-write discards the partial word
    da = 64'hAAAA_AAAA_AAAA_AAAA; dc = 64'hCCCC_CCCC_CCCC_CCCC; dd = 64'hDDDD_DDDD_DDDD_DDDD;
    push_beat(da, 8'h01);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    chk("mrst_v", 256'(fifo_wr_v_o), 256'(0));
    chk("mrst_err", 256'(fifo_error_o), 256'(0));
    push_beat(dc, 8'h0C);
    chk("mrst_v_half", 256'(fifo_wr_v_o), 256'(0));
    push_beat(dd, 8'h0D);
    chk("mrst_v_word", 256'(fifo_wr_v_o), 256'(1));
    chk("mrst_word", 256'(fifo_wr_data_o), 256'({dd, 8'h0D, dc, 8'h0C}));
    fifo_wr_ready_i = 1'b1;
    cyc();
    fifo_wr_ready_i = 1'b0;
    chk("mrst_single", 256'(fifo_wr_v_o), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
